// File: rtl/can_crc_engine_pkg.sv
// ---------------------------------------------------------------------------
// can_crc_engine_pkg
//
// Shared definitions for the parametrised CAN CRC engine.
//
// Contents:
//   crc_state_t     - FSM state encoding for the CRC engine.
//   CAN_CRC15_POLY  - classic CAN generator polynomial.
//   CAN_CRC17_POLY  - CAN FD polynomial for payloads up to 16 bytes.
//   CAN_CRC21_POLY  - CAN FD polynomial for payloads above 16 bytes.
//
// The polynomials leave out the implicit x^WIDTH term. This matches the
// LFSR step, which XORs the polynomial into the shifted register whenever
// the feedback bit is 1.
// ---------------------------------------------------------------------------
package can_crc_engine_pkg;

   // IDLE  : frame just started, nothing accumulated yet
   // ACCUM : frame bits are being folded into the LFSR
   // CHECK : walking the CRC field, one LFSR bit per bit time
   // DONE  : CRC field finished, inputs ignored until Clear/reset
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } crc_state_t;

   localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;
   localparam logic [16:0] CAN_CRC17_POLY = 17'h1685B;
   localparam logic [20:0] CAN_CRC21_POLY = 21'h102899;

endpackage

// File: rtl/can_crc_engine_if.sv
// ---------------------------------------------------------------------------
// can_crc_engine_if
//
// Connects the bit-timing/frame FSM and the TX/RX bit streams to the CRC
// engine.
//
// Parameter:
//   CRC_WIDTH    width of CRC_Value; must match the engine's CRC_WIDTH
//
// Signals:
//   Clear        synchronous frame restart (start of frame)
//   Mode         0 = check the received CRC, 1 = generate/transmit the CRC
//   Data_Phase   the current bit is a CRC-covered frame bit
//   Crc_Phase    the current bit is a CRC-field bit
//   Bit_Entrada  serial input bit (RX line or TX data)
//   Bit_Saida    serial CRC bit towards TX; recessive (1) when not driving
//   CRC_Value    current LFSR contents
//   CRC_Done     one-clock pulse after the last CRC bit has been processed
//   CRC_monitor  sticky CRC mismatch flag
//
// Modports:
//   master  the frame FSM / bit-stream side
//   slave   the CRC engine
// ---------------------------------------------------------------------------
interface can_crc_engine_if #(
   parameter int CRC_WIDTH = 15
) ();

   logic                 Clear;
   logic                 Mode;
   logic                 Data_Phase;
   logic                 Crc_Phase;
   logic                 Bit_Entrada;
   logic                 Bit_Saida;
   logic [CRC_WIDTH-1:0] CRC_Value;
   logic                 CRC_Done;
   logic                 CRC_monitor;

   modport master (
      output Clear,
      output Mode,
      output Data_Phase,
      output Crc_Phase,
      output Bit_Entrada,
      input  Bit_Saida,
      input  CRC_Value,
      input  CRC_Done,
      input  CRC_monitor
   );

   modport slave (
      input  Clear,
      input  Mode,
      input  Data_Phase,
      input  Crc_Phase,
      input  Bit_Entrada,
      output Bit_Saida,
      output CRC_Value,
      output CRC_Done,
      output CRC_monitor
   );

endinterface

// File: rtl/can_crc_engine_bit_tick.sv
// ---------------------------------------------------------------------------
// can_bit_tick
//
// Bit-time divider for the CRC engine. It counts 0..CLKS_PER_BIT-1 and
// wraps. tick is high during the last clock of each bit time; the engine
// samples its inputs only when tick is high.
//
// Parameter:
//   CLKS_PER_BIT  clocks per bit time (>= 1)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   clear  in   synchronous realign; the counter restarts at 0
//   tick   out  high on the last clock of each bit time
// ---------------------------------------------------------------------------
module can_bit_tick #(
   parameter int CLKS_PER_BIT = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   // With CLKS_PER_BIT == 1 the counter keeps one bit that stays at 0, so
   // tick is held high continuously.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] count;

   // Free-running bit-time counter. clear has priority over the wrap, so
   // the first tick after a clear comes a full CLKS_PER_BIT clocks later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign tick = (count == LAST);

endmodule

// File: rtl/can_crc_engine.sv
// ---------------------------------------------------------------------------
// can_crc_engine
//
// Parametrised CAN CRC generator/checker. A serial LFSR runs over frame
// bits that are sampled once per bit time.
//   Check mode (Mode=0)   : the received CRC field is compared MSB first
//                           against the frozen LFSR. Any difference sets a
//                           sticky error flag.
//   Generate mode (Mode=1): the frozen LFSR is shifted out MSB first on
//                           Bit_Saida.
//
// Parameters:
//   CRC_WIDTH     LFSR width (15 classic CAN, 17/21 CAN FD)
//   CRC_POLY      generator polynomial, implicit x^CRC_WIDTH term omitted
//   CRC_INIT      LFSR value after reset/Clear
//   CLKS_PER_BIT  clocks per bit time (>= 1)
//
// Ports:
//   Clock_TB  in   system clock, rising edge
//   Reset     in   asynchronous active-high reset
//   bus       can_crc_engine_if.slave (Clear, Mode, Data_Phase, Crc_Phase,
//             Bit_Entrada in; Bit_Saida, CRC_Value, CRC_Done,
//             CRC_monitor out)
// ---------------------------------------------------------------------------
module can_crc_engine
   import can_crc_engine_pkg::*;
#(
   parameter int                   CRC_WIDTH    = 15,
   parameter logic [CRC_WIDTH-1:0] CRC_POLY     = CAN_CRC15_POLY,
   parameter logic [CRC_WIDTH-1:0] CRC_INIT     = '0,
   parameter int                   CLKS_PER_BIT = 10
) (
   input  logic                  Clock_TB,
   input  logic                  Reset,
   can_crc_engine_if.slave       bus
);

   localparam int IW = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
   localparam logic [IW-1:0] INDEX_TOP = IW'(CRC_WIDTH - 1);

   crc_state_t           state;
   crc_state_t           next_state;
   logic [CRC_WIDTH-1:0] lfsr;
   logic [CRC_WIDTH-1:0] next_lfsr;
   logic [IW-1:0]        index;
   logic [IW-1:0]        next_index;
   logic                 done;
   logic                 next_done;
   logic                 monitor;
   logic                 next_monitor;
   logic                 tick;
   logic                 crc_bit;
   logic                 mismatch;

   // One serial LFSR step. The feedback is the incoming bit XORed with the
   // register MSB; when it is 1 the polynomial is folded into the shifted
   // value.
   function automatic logic [CRC_WIDTH-1:0] lfsr_step(
      input logic [CRC_WIDTH-1:0] cur,
      input logic                 din
   );
      logic fb;
      fb = din ^ cur[CRC_WIDTH-1];
      return {cur[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   endfunction

   can_bit_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_tick (
      .clk   (Clock_TB),
      .rst   (Reset),
      .clear (bus.Clear),
      .tick  (tick)
   );

   // The LFSR bit at the current index is the CRC bit for this bit time.
   // A received bit that differs from it is a mismatch, but only in check
   // mode. While CRC bits are processed the LFSR is frozen; only the index
   // moves.
   assign crc_bit  = lfsr[index];
   assign mismatch = !bus.Mode && (bus.Bit_Entrada != crc_bit);

   // Next-state logic. Nothing changes between ticks. CRC_Done is a
   // one-clock pulse, so its default is 0 on every cycle, whether or not
   // tick is high.
   always_comb begin
      next_state   = state;
      next_lfsr    = lfsr;
      next_index   = index;
      next_done    = 1'b0;
      next_monitor = monitor;

      if (tick) begin
         case (state)
            IDLE, ACCUM: begin
               // Data_Phase wins over Crc_Phase while the frame body is
               // still being accumulated.
               if (bus.Data_Phase) begin
                  next_lfsr  = lfsr_step(lfsr, bus.Bit_Entrada);
                  next_state = ACCUM;
               end else if (bus.Crc_Phase) begin
                  if (mismatch) begin
                     next_monitor = 1'b1;
                  end
                  if (index == '0) begin
                     next_state = DONE;
                     next_done  = 1'b1;
                  end else begin
                     next_index = index - 1'b1;
                     next_state = CHECK;
                  end
               end
            end

            CHECK: begin
               // Data_Phase has no effect here. A bit time without
               // Crc_Phase leaves the index where it is.
               if (bus.Crc_Phase) begin
                  if (mismatch) begin
                     next_monitor = 1'b1;
                  end
                  if (index == '0) begin
                     next_state = DONE;
                     next_done  = 1'b1;
                  end else begin
                     next_index = index - 1'b1;
                  end
               end
            end

            DONE: begin
               next_state = DONE;
            end

            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

   // State register. Clear applies the reset values synchronously and has
   // priority over any tick in the same cycle.
   always_ff @(posedge Clock_TB or posedge Reset) begin
      if (Reset) begin
         state   <= IDLE;
         lfsr    <= CRC_INIT;
         index   <= INDEX_TOP;
         done    <= 1'b0;
         monitor <= 1'b0;
      end else if (bus.Clear) begin
         state   <= IDLE;
         lfsr    <= CRC_INIT;
         index   <= INDEX_TOP;
         done    <= 1'b0;
         monitor <= 1'b0;
      end else begin
         state   <= next_state;
         lfsr    <= next_lfsr;
         index   <= next_index;
         done    <= next_done;
         monitor <= next_monitor;
      end
   end

   // The transmit bit comes straight from the LFSR, so TX sees it in the
   // same bit time that Crc_Phase is raised. It stays recessive in check
   // mode and after the CRC field has finished.
   assign bus.Bit_Saida = (bus.Mode && bus.Crc_Phase && (state != DONE)) ? crc_bit : 1'b1;

   assign bus.CRC_Value   = lfsr;
   assign bus.CRC_Done    = done;
   assign bus.CRC_monitor = monitor;

endmodule
